// File: rtl/bht_table_pkg.sv
// Shared definitions for the branch-history table: entry layout and FSM state encoding.
package bht_table_pkg;

  localparam int BHT_CNT_MSB = 33;
  localparam int BHT_CNT_LSB = 32;
  localparam int BHT_TGT_MSB = 31;
  localparam int BHT_ENTRY_W = BHT_CNT_MSB + 1;

  // One table entry: 2-bit saturating count above the 32-bit branch target.
  typedef struct packed {
    logic [1:0]  count;
    logic [31:0] target;
  } bht_entry_t;

  // Clear-sweep FSM encoding.
  localparam logic [0:0] ST_SWEEP = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Assemble an entry from its fields; data is never modified by the table.
  function automatic bht_entry_t bht_make_entry(input logic [1:0] count, input logic [31:0] target);
    bht_entry_t e;
    e.count  = count;
    e.target = target;
    return e;
  endfunction

endpackage

// File: rtl/bht_table_ram.sv
// Plain storage array: one write port, two synchronous read ports, no reset.
// Port 1 reads the old contents on a same-address write; port 2 is write-first.
module bht_ram #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 34
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr1,
  output logic [DWIDTH-1:0] q1,
  input  logic [AWIDTH-1:0] raddr2,
  output logic [DWIDTH-1:0] q2
);

  localparam int DEPTH = 32'd1 << AWIDTH;

  logic [DWIDTH-1:0] mem_r [0:DEPTH-1];

  // Array write plus registered reads for both ports.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    q1 <= mem_r[raddr1];
    if (we && (waddr == raddr2)) begin
      q2 <= wdata;
    end else begin
      q2 <= mem_r[raddr2];
    end
  end

endmodule

// File: rtl/bht_table.sv
// Branch-history table: wraps the storage array with the clear-sweep FSM,
// the port-1 hold/capture logic and the port-1 write bypass.
import bht_table_pkg::*;

module bht_table #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = BHT_ENTRY_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold1,
  input  logic [AWIDTH-1:0] add1,
  output logic [DWIDTH-1:0] rdata1,
  input  logic [AWIDTH-1:0] add2,
  input  logic              wen2,
  input  logic [DWIDTH-1:0] wdata2,
  output logic [DWIDTH-1:0] rdata2,
  output logic              busy
);

  localparam logic [AWIDTH-1:0] IDX_LAST = {AWIDTH{1'b1}};
  localparam logic [AWIDTH-1:0] IDX_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};

  logic [0:0]        state_r;
  logic [AWIDTH-1:0] sweep_idx_r;
  logic [AWIDTH-1:0] cap_idx_r;
  logic              zero_r;
  logic              byp1_r;
  logic [DWIDTH-1:0] byp1_data_r;

  logic              we_s;
  logic [AWIDTH-1:0] waddr_s;
  logic [DWIDTH-1:0] wdata_s;
  logic [AWIDTH-1:0] raddr1_s;
  logic [DWIDTH-1:0] q1_s;
  logic [DWIDTH-1:0] q2_s;

  // Sweep FSM: clear every entry after reset or flush, then serve traffic.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_r     <= ST_SWEEP;
      sweep_idx_r <= {AWIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_SWEEP: begin
          if (sweep_idx_r == IDX_LAST) begin
            state_r     <= ST_READY;
            sweep_idx_r <= {AWIDTH{1'b0}};
          end else begin
            sweep_idx_r <= sweep_idx_r + IDX_ONE;
          end
        end
        ST_READY: begin
          state_r <= ST_READY;
        end
        default: begin
          state_r     <= ST_SWEEP;
          sweep_idx_r <= {AWIDTH{1'b0}};
        end
      endcase
    end
  end

  // Single write port: the sweep owns it while clearing, port 2 otherwise.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = add2;
    wdata_s = wdata2;
    if (state_r == ST_SWEEP) begin
      we_s    = 1'b1;
      waddr_s = sweep_idx_r;
      wdata_s = {DWIDTH{1'b0}};
    end else begin
      we_s    = wen2;
      waddr_s = add2;
      wdata_s = wdata2;
    end
  end

  // While held, keep re-reading the captured index so the output stays coherent.
  always_comb begin
    raddr1_s = add1;
    if (hold1) begin
      raddr1_s = cap_idx_r;
    end else begin
      raddr1_s = add1;
    end
  end

  // Capture index, output-zeroing flag and port-1 bypass data.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_idx_r   <= {AWIDTH{1'b0}};
      zero_r      <= 1'b1;
      byp1_r      <= 1'b0;
      byp1_data_r <= {DWIDTH{1'b0}};
    end else begin
      if (!hold1) begin
        cap_idx_r <= add1;
      end
      // Outputs read as zero (no prediction) while the table is being cleared.
      zero_r      <= flush || (state_r == ST_SWEEP);
      byp1_r      <= we_s && (waddr_s == raddr1_s);
      byp1_data_r <= wdata_s;
    end
  end

  bht_ram #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_ram (
    .clk    (clk),
    .we     (we_s),
    .waddr  (waddr_s),
    .wdata  (wdata_s),
    .raddr1 (raddr1_s),
    .q1     (q1_s),
    .raddr2 (add2),
    .q2     (q2_s)
  );

  assign rdata1 = zero_r ? {DWIDTH{1'b0}} : (byp1_r ? byp1_data_r : q1_s);
  assign rdata2 = zero_r ? {DWIDTH{1'b0}} : q2_s;
  assign busy   = (state_r == ST_SWEEP);

endmodule

// File: tb/tb_bht_table.sv
// Directed self-checking bench for bht_table.
module tb_bht_table;

  localparam int AW = 10;
  localparam int DW = 34;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          hold1;
  logic [AW-1:0] add1;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] add2;
  logic          wen2;
  logic [DW-1:0] wdata2;
  logic [DW-1:0] rdata2;
  logic          busy;

  int vectors = 0;
  int errors  = 0;

  bht_table #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .flush  (flush),
    .hold1  (hold1),
    .add1   (add1),
    .rdata1 (rdata1),
    .add2   (add2),
    .wen2   (wen2),
    .wdata2 (wdata2),
    .rdata2 (rdata2),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // One clock: inputs set beforehand take effect at the edge; sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts busy cycles from now (busy expected high) with zero outputs throughout.
  // Optionally attempts dropped writes at given sweep cycles.
  task automatic run_sweep(input string name, input bit try_writes);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1100) begin
      vectors++;
      if (rdata1 !== '0 || rdata2 !== '0) begin
        errors++;
        $display("FAIL %s_zero cycle %0d: rdata1=%h rdata2=%h required 0", name, n, rdata1, rdata2);
      end
      wen2 = 1'b0;
      if (try_writes && n == 3) begin
        wen2 = 1'b1; add2 = 10'h200; wdata2 = 34'h3_DEAD_BEEF;
      end
      if (try_writes && n == 700) begin
        wen2 = 1'b1; add2 = 10'h005; wdata2 = 34'h2_CAFE_0001;
      end
      n++;
      tick();
    end
    wen2 = 1'b0;
    vectors++;
    if (n != 1024) begin
      errors++;
      $display("FAIL %s_busy_len: busy cycles=%0d required 1024", name, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; hold1 = 1'b0; wen2 = 1'b0;
    add1 = '0; add2 = '0; wdata2 = '0;
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b1 || rdata1 !== '0 || rdata2 !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rdata1=%h rdata2=%h required 1,0,0", busy, rdata1, rdata2);
    end
    run_sweep("reset_sweep", 1'b0);
    add1 = 10'h3FF; add2 = 10'h3FF;
    tick();
    vectors++;
    if (rdata1 !== 34'h0 || rdata2 !== 34'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_cleared_3ff: rdata1=%h rdata2=%h busy=%b required 0,0,0", rdata1, rdata2, busy);
    end
  endtask

  task automatic test_write_read();
    wen2 = 1'b1; add2 = 10'h005; wdata2 = {2'b11, 32'h0000_1000}; add1 = 10'h000;
    tick();
    vectors++;
    if (rdata2 !== 34'h3_0000_1000) begin
      errors++;
      $display("FAIL write_first_p2: rdata2=%h required 300001000", rdata2);
    end
    wen2 = 1'b0; add1 = 10'h005;
    tick();
    vectors++;
    if (rdata1 !== 34'h3_0000_1000) begin
      errors++;
      $display("FAIL write_then_read_p1: rdata1=%h required 300001000", rdata1);
    end
  endtask

  task automatic test_bypass();
    add1 = 10'h07A; add2 = 10'h07A; wen2 = 1'b1; wdata2 = {2'b10, 32'h0000_2040}; hold1 = 1'b0;
    tick();
    wen2 = 1'b0;
    vectors++;
    if (rdata1 !== 34'h2_0000_2040) begin
      errors++;
      $display("FAIL bypass_p1: rdata1=%h required 200002040", rdata1);
    end
    // Write elsewhere while port 1 reads 0x07A: independent.
    add2 = 10'h07B; wen2 = 1'b1; wdata2 = 34'h1_1111_1111;
    tick();
    wen2 = 1'b0;
    vectors++;
    if (rdata1 !== 34'h2_0000_2040) begin
      errors++;
      $display("FAIL bypass_indep: rdata1=%h required 200002040", rdata1);
    end
  endtask

  task automatic test_hold();
    wen2 = 1'b1; add2 = 10'h011; wdata2 = 34'h1_0000_0400;
    tick();
    wen2 = 1'b0; add1 = 10'h011; hold1 = 1'b0;
    tick();
    vectors++;
    if (rdata1 !== 34'h1_0000_0400) begin
      errors++;
      $display("FAIL hold_capture: rdata1=%h required 100000400", rdata1);
    end
    hold1 = 1'b1; add1 = 10'h005;
    tick();
    vectors++;
    if (rdata1 !== 34'h1_0000_0400) begin
      errors++;
      $display("FAIL hold_freeze: rdata1=%h required 100000400", rdata1);
    end
    wen2 = 1'b1; add2 = 10'h011; wdata2 = 34'h3_0000_0800;
    tick();
    vectors++;
    if (rdata1 !== 34'h3_0000_0800) begin
      errors++;
      $display("FAIL hold_coherent: rdata1=%h required 300000800", rdata1);
    end
    for (int i = 0; i < 3; i++) begin
      wen2 = (i == 1); add2 = 10'h012; wdata2 = 34'h2_2222_2222;
      tick();
      vectors++;
      if (rdata1 !== 34'h3_0000_0800) begin
        errors++;
        $display("FAIL hold_stay_%0d: rdata1=%h required 300000800", i, rdata1);
      end
    end
    wen2 = 1'b0; hold1 = 1'b0; add1 = 10'h005;
    tick();
    vectors++;
    if (rdata1 !== 34'h3_0000_1000) begin
      errors++;
      $display("FAIL hold_release: rdata1=%h required 300001000", rdata1);
    end
  endtask

  task automatic test_port2();
    wen2 = 1'b1; add2 = 10'h100; wdata2 = 34'h2_0000_0C00;
    tick();
    vectors++;
    if (rdata2 !== 34'h2_0000_0C00) begin
      errors++;
      $display("FAIL p2_write: rdata2=%h required 200000c00", rdata2);
    end
    wen2 = 1'b0;
    tick();
    vectors++;
    if (rdata2 !== 34'h2_0000_0C00) begin
      errors++;
      $display("FAIL p2_read: rdata2=%h required 200000c00", rdata2);
    end
    add2 = 10'h005;
    tick();
    vectors++;
    if (rdata2 !== 34'h3_0000_1000) begin
      errors++;
      $display("FAIL p2_read_005: rdata2=%h required 300001000", rdata2);
    end
  endtask

  task automatic test_flush();
    add1 = 10'h005; add2 = 10'h005; flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy: busy=%b required 1", busy);
    end
    run_sweep("flush_sweep", 1'b1);
    add1 = 10'h005; add2 = 10'h200;
    tick();
    vectors++;
    if (rdata1 !== 34'h0 || rdata2 !== 34'h0) begin
      errors++;
      $display("FAIL flush_cleared: rdata1=%h rdata2=%h required 0,0", rdata1, rdata2);
    end
    // Second flush mid-sweep restarts the full count.
    wen2 = 1'b1; add2 = 10'h0AA; wdata2 = 34'h1_0000_00AA;
    tick();
    wen2 = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_sweep("reflush_sweep", 1'b0);
    add1 = 10'h0AA; add2 = 10'h0AA;
    tick();
    vectors++;
    if (rdata1 !== 34'h0 || rdata2 !== 34'h0) begin
      errors++;
      $display("FAIL reflush_cleared: rdata1=%h rdata2=%h required 0,0", rdata1, rdata2);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_hold();
    test_port2();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bht_table.md
Name: bht_table

Overview:
- Storage and responder side of the dynamic branch-prediction table.
- Serves the predictor's fetch-side read port (add1/rdata1) and its execute-side read/write port (add2/wen2/wdata2/rdata2).
- Each entry is {count[1:0], target[31:0]}.
- Provides 1-cycle synchronous reads, write-to-read bypass, a pause hold and a hardware sweep that clears all entries after reset or on a flush request.

Parameters:
- AWIDTH, 10, entry index width; depth = 2^AWIDTH.
- DWIDTH, 34, entry width: 2-bit saturating count in [33:32], branch target in [31:0].

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high.
- flush, input, 1, pulse; restarts the clear sweep from index 0.
- hold1, input, 1, predictor pause; freezes port-1 output.
- add1, input, AWIDTH, port-1 read index (fetch PC[AWIDTH+1:2]).
- rdata1, output, DWIDTH, port-1 read data, valid one cycle after add1.
- add2, input, AWIDTH, port-2 index: write index when wen2=1, read index otherwise.
- wen2, input, 1, port-2 write enable.
- wdata2, input, DWIDTH, port-2 write data.
- rdata2, output, DWIDTH, port-2 read data, valid one cycle after add2.
- busy, output, 1, high while the clear sweep is in progress.

Behaviour:
- Reset: rdata1=0, rdata2=0, busy=1; FSM enters SWEEP with sweep_idx=0. Contents are not cleared by reset itself, only by the sweep.
- FSM states: SWEEP and READY.
  - SWEEP: each cycle writes 0 to entry sweep_idx, then sweep_idx+1.
  - When sweep_idx = 2^AWIDTH-1 is written, go to READY next cycle; busy falls in that same cycle. Sweep length = 2^AWIDTH cycles.
  - READY to SWEEP: flush=1 in any cycle; sweep_idx=0 and busy=1 next cycle.
  - flush during SWEEP restarts at 0.
  - reset has priority over flush.
- During SWEEP:
  - wen2 is ignored (the write is dropped).
  - rdata1 and rdata2 register 0 every cycle, so no prediction is possible (count=0).
- Port-1 read in READY, when hold1=0: rdata1 at t+1 = mem[add1 at t].
- Port-1 hold, when hold1=1: rdata1 and the captured index are retained.
  - Exception: if wen2 writes the captured index in that cycle, rdata1 becomes wdata2 at t+1, keeping the held entry coherent.
- Port-2 read, wen2=0: rdata2 at t+1 = mem[add2 at t].
- Port-2 write, wen2=1: mem[add2] <= wdata2; rdata2 at t+1 = wdata2 (write-first).
- Port-1 vs write collision: add1 == add2 with wen2=1 in the same cycle and hold1=0 gives rdata1 at t+1 = wdata2 (bypass). Differing indices are independent.
- Storage: one write port (sweep mux or wen2) and two read ports. Data passes through unmodified; the block does no arithmetic on count or target.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - BHT_CNT_MSB=33, BHT_CNT_LSB=32, BHT_TGT_MSB=31.
  - Entry struct/typedef {count, target}.
  - FSM state encoding SWEEP=1'b0, READY=1'b1.
- One natural sub-module: bht_ram.
  - Plain 1-write / 2-read synchronous RAM with write-first port 2 and no reset.
  - bht_table wraps it with the sweep FSM, hold register and bypass muxes.

Test Plan:
- Reset then idle 1024 cycles. Required: busy=1 for exactly 1024 cycles after reset deasserts, then 0. Reading add1=0x3FF afterwards gives rdata1=0.
- READY; wen2=1, add2=0x005, wdata2={2'b11,32'h0000_1000}. Next cycle add1=0x005. Required: rdata1 on the following cycle = 34'h3_0000_1000.
- Same cycle: add1=add2=0x07A, wen2=1, wdata2={2'b10,32'h0000_2040}, hold1=0. Required: rdata1 at t+1 = 34'h2_0000_2040.
- Entry 0x011 = 34'h1_0000_0400 and captured with hold1=1. A write of 34'h3_0000_0800 lands on 0x011 while held. Required: rdata1 = 34'h3_0000_0800 and stays so until hold1 drops.
- wen2=1, add2=0x100, wdata2=34'h2_0000_0C00. Required: rdata2 at t+1 = 34'h2_0000_0C00. Next cycle read add2=0x100 with wen2=0; required: rdata2 still 34'h2_0000_0C00.
- Flush pulse while entry 0x005 is nonzero; attempt wen2 to 0x200 at sweep cycle 3. Required: busy=1 for 1024 cycles, and rdata1/rdata2 = 0 throughout. Afterwards 0x005 and 0x200 both read 0. A second flush mid-sweep extends busy to 1024 cycles from that flush.
